mips_if2id: RTL
===============

MIPS_IF2ID -- requirements
Module: mips_if2id

Interface
REQ-001 SHALL have parameter INST_W, default 32, instruction width.
REQ-002 SHALL have parameter ADDR_W, default 32, PC width.
REQ-003 SHALL have parameter RFIDX_W, default 5, register index width.
REQ-004 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ext_stall  in  1  downstream stall; hold the IF/ID contents.
REQ-008 SHALL have port flush  in  1  branch/jump mispredict flush from EX.
REQ-009 SHALL have ports if_inst in INST_W, if_pc_incr in ADDR_W, if_prdt_taken in 1, if_rs_idx in RFIDX_W, if_rt_idx in RFIDX_W: the fetched instruction and its early-decoded fields from IF.
REQ-010 SHALL have ports id_is_load in 1 and id_load_rt in RFIDX_W: the load flag and load destination of the instruction currently in ID, from the ID decoder.
REQ-011 SHALL have ports id_inst out INST_W, id_pc_incr out ADDR_W, id_prdt_taken out 1, id_rs_idx out RFIDX_W, id_rt_idx out RFIDX_W, id_valid out 1: the registered IF/ID contents.
REQ-012 SHALL have port if_stall  out  1  hold request to the IF PC register.
REQ-013 SHALL have ports perf_hzd_cnt out CNT_W and perf_flush_cnt out CNT_W: load-use bubble count and flush count.

Function
REQ-014 SHALL compute hazard = id_valid & id_is_load & (id_load_rt != 0) & ((if_rs_idx == id_load_rt) | (if_rt_idx == id_load_rt)), combinationally.
REQ-015 SHALL treat index 0 as "no operand" and never raise hazard for it.
REQ-016 SHALL resolve simultaneous events each cycle in the priority order flush > ext_stall > hazard > normal advance.
REQ-017 On flush, SHALL load a bubble on the next edge: id_valid=0, id_inst=0 (NOP), id_prdt_taken=0, id_rs_idx=0, id_rt_idx=0, id_pc_incr=0.
REQ-018 On ext_stall without flush, SHALL hold every id_* register unchanged.
REQ-019 On hazard without flush or ext_stall, SHALL load a bubble as in REQ-017, leaving the IF instruction in IF.
REQ-020 On normal advance, SHALL capture all if_* inputs into the id_* registers and set id_valid=1 on the next edge, giving 1-cycle latency.
REQ-021 SHALL drive if_stall = ~flush & (ext_stall | hazard), combinationally.
REQ-022 SHALL insert exactly one bubble per load-use pair: the bubble clears id_valid, so hazard deasserts on the next cycle.
REQ-023 SHALL increment perf_hzd_cnt once per cycle in which REQ-019 applies.
REQ-024 SHALL increment perf_flush_cnt once per cycle in which flush is high.
REQ-025 Both counters SHALL saturate at all-ones with no wrap-around.
REQ-026 SHALL contain no combinational path from if_inst to if_stall; if_stall depends only on the index inputs, the id_* registers and the control inputs.

Reset
REQ-027 While rst is high, SHALL hold id_valid=0, all other id_* outputs=0 and both counters=0, asynchronously.
REQ-028 SHALL drive if_stall=0 during reset, since id_valid=0 and the stall inputs are don't-care.
REQ-029 Reset asserted mid-stall or mid-flush SHALL override all state; the first edge after rst falls SHALL behave as normal advance.

Verification
REQ-030 Normal flow: inst 0x8C220004, pc_incr 0x104, no stalls -> next cycle id_inst=0x8C220004, id_pc_incr=0x104, id_valid=1, if_stall=0.
REQ-031 Load-use: ID holds lw with rt=2 (id_is_load=1, id_load_rt=2, id_valid=1), IF rs_idx=2 -> if_stall=1; next cycle id_valid=0, id_inst=0, perf_hzd_cnt=1; the following cycle if_stall=0 and the dependent instruction is captured.
REQ-032 Zero index: id_load_rt=0 with if_rs_idx=0 -> hazard=0 and if_stall=0.
REQ-033 Flush during ext_stall and hazard in the same cycle -> if_stall=0; next cycle bubble loaded, perf_flush_cnt increments, perf_hzd_cnt unchanged.
REQ-034 ext_stall held 3 cycles -> id_* unchanged for 3 cycles, if_stall=1 throughout, counters unchanged.
REQ-035 Async reset pulsed between clock edges while id_valid=1 -> id_valid=0 and counters=0 immediately, with no clock edge required; counter preloaded to all-ones via repeated hazards stays all-ones.

Source files
------------

// File: rtl/mips_if2id.sv
// IF/ID pipeline register for a 5-stage MIPS core with load-use hazard detection,
// flush/stall arbitration and saturating hazard/flush performance counters.
module mips_if2id #(
  parameter int unsigned INST_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RFIDX_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_stall,
  input  logic               flush,
  input  logic [INST_W-1:0]  if_inst,
  input  logic [ADDR_W-1:0]  if_pc_incr,
  input  logic               if_prdt_taken,
  input  logic [RFIDX_W-1:0] if_rs_idx,
  input  logic [RFIDX_W-1:0] if_rt_idx,
  input  logic               id_is_load,
  input  logic [RFIDX_W-1:0] id_load_rt,
  output logic [INST_W-1:0]  id_inst,
  output logic [ADDR_W-1:0]  id_pc_incr,
  output logic               id_prdt_taken,
  output logic [RFIDX_W-1:0] id_rs_idx,
  output logic [RFIDX_W-1:0] id_rt_idx,
  output logic               id_valid,
  output logic               if_stall,
  output logic [CNT_W-1:0]   perf_hzd_cnt,
  output logic [CNT_W-1:0]   perf_flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [INST_W-1:0]  inst_q,  inst_d;
  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic               prdt_q,  prdt_d;
  logic [RFIDX_W-1:0] rs_q,    rs_d;
  logic [RFIDX_W-1:0] rt_q,    rt_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   hzd_q,   hzd_d;
  logic [CNT_W-1:0]   flsh_q,  flsh_d;

  logic hazard_c;
  logic bubble_c;
  logic hold_c;
  logic hzd_evt_c;

  // Index 0 is "no operand", so a load to $0 never creates a dependency.
  assign hazard_c = valid_q & id_is_load & (id_load_rt != '0) &
                    ((if_rs_idx == id_load_rt) | (if_rt_idx == id_load_rt));

  assign hzd_evt_c = ~flush & ~ext_stall & hazard_c;
  assign hold_c    = ~flush & ext_stall;
  assign bubble_c  = flush | hzd_evt_c;

  assign if_stall  = ~rst & ~flush & (ext_stall | hazard_c);

  // Next-state selection: flush > ext_stall > hazard > advance.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    prdt_d  = prdt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    valid_d = valid_q;
    if (bubble_c) begin
      inst_d  = '0;
      pc_d    = '0;
      prdt_d  = 1'b0;
      rs_d    = '0;
      rt_d    = '0;
      valid_d = 1'b0;
    end else if (!hold_c) begin
      inst_d  = if_inst;
      pc_d    = if_pc_incr;
      prdt_d  = if_prdt_taken;
      rs_d    = if_rs_idx;
      rt_d    = if_rt_idx;
      valid_d = 1'b1;
    end
  end

  // Saturating performance counters.
  always_comb begin
    hzd_d  = hzd_q;
    flsh_d = flsh_q;
    if (hzd_evt_c && (hzd_q != CNT_MAX)) hzd_d = hzd_q + CNT_W'(1);
    if (flush && (flsh_q != CNT_MAX))    flsh_d = flsh_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= '0;
      pc_q    <= '0;
      prdt_q  <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      valid_q <= 1'b0;
      hzd_q   <= '0;
      flsh_q  <= '0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      prdt_q  <= prdt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      valid_q <= valid_d;
      hzd_q   <= hzd_d;
      flsh_q  <= flsh_d;
    end
  end

  assign id_inst        = inst_q;
  assign id_pc_incr     = pc_q;
  assign id_prdt_taken  = prdt_q;
  assign id_rs_idx      = rs_q;
  assign id_rt_idx      = rt_q;
  assign id_valid       = valid_q;
  assign perf_hzd_cnt   = hzd_q;
  assign perf_flush_cnt = flsh_q;

endmodule
